// File: rtl/blob_pkg.sv
// Shared constants and state encoding for the blob label ping-pong controller.
package blob_pkg;

    localparam int LBITS    = 8;
    localparam int XBITS    = 8;
    localparam int YBITS    = 8;
    localparam int DEF_COLS = 256;
    localparam int DEF_ROWS = 254;
    localparam int AW       = 1 + YBITS + XBITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } state_t;

endpackage

// File: rtl/blob_xy_counter.sv
// Raster x/y counter for one frame; flags the final pixel so the parent can swap banks.
module blob_xy_counter #(
    parameter int COLS  = blob_pkg::DEF_COLS,
    parameter int ROWS  = blob_pkg::DEF_ROWS,
    parameter int XBITS = blob_pkg::XBITS,
    parameter int YBITS = blob_pkg::YBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [XBITS-1:0] x,
    output logic [YBITS-1:0] y,
    output logic             last
);
    import blob_pkg::*;

    localparam logic [XBITS-1:0] XLAST = XBITS'(COLS - 1);
    localparam logic [YBITS-1:0] YLAST = YBITS'(ROWS - 1);

    assign last = (x == XLAST) && (y == YLAST);

    // The final pixel wraps both coordinates, leaving the counter ready for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            if (x == XLAST) begin
                x <= '0;
                y <= (y == YLAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/blob_label_pingpong_ctrl.sv
// Ping-pong label buffer control: pass A writes bank 'bank', pass B reads the other bank.
module blob_label_pingpong_ctrl #(
    parameter int COLS  = blob_pkg::DEF_COLS,
    parameter int ROWS  = blob_pkg::DEF_ROWS,
    parameter int XBITS = blob_pkg::XBITS,
    parameter int YBITS = blob_pkg::YBITS,
    parameter int LBITS = blob_pkg::LBITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_valid,
    input  logic                   line_valid,
    input  logic [LBITS-1:0]       label_in,
    input  logic                   clr_err,
    output logic                   mem_we,
    output logic [YBITS+XBITS:0]   mem_waddr,
    output logic [LBITS-1:0]       mem_wdata,
    output logic [YBITS+XBITS:0]   mem_raddr,
    input  logic [LBITS-1:0]       mem_rdata,
    output logic [LBITS-1:0]       label_out,
    output logic                   label_valid,
    output logic                   bank,
    output logic                   prev_valid,
    output logic                   frame_done,
    output logic                   err_short,
    output logic                   err_over
);
    import blob_pkg::*;

    state_t             state, state_next;
    logic               accept, wr_en, complete, short_end, over_hit;
    logic               last, rd_gate;
    logic [XBITS-1:0]   x;
    logic [YBITS-1:0]   y;

    assign accept = frame_valid & line_valid;

    blob_xy_counter #(
        .COLS(COLS), .ROWS(ROWS), .XBITS(XBITS), .YBITS(YBITS)
    ) u_xy (
        .clk(clk), .rst_n(rst_n), .inc(wr_en), .clr(short_end),
        .x(x), .y(y), .last(last)
    );

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        complete   = 1'b0;
        short_end  = 1'b0;
        over_hit   = 1'b0;
        case (state)
            IDLE: begin
                wr_en    = accept;
                complete = accept & last;
                if (frame_valid)
                    state_next = complete ? FULL : ACTIVE;
            end
            ACTIVE: begin
                wr_en    = accept;
                complete = accept & last;
                if (complete) begin
                    state_next = FULL;
                end else if (!frame_valid) begin
                    short_end  = (x != '0) || (y != '0);
                    state_next = IDLE;
                end
            end
            FULL: begin
                over_hit = accept;
                if (!frame_valid)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Write strobe is held low during reset so the RAM is never touched while the block is cleared.
    assign mem_we    = wr_en & rst_n;
    assign mem_waddr = {bank, y, x};
    assign mem_wdata = label_in;
    assign mem_raddr = {~bank, y, x};
    assign label_out = rd_gate ? mem_rdata : '0;

    // rd_gate lines up with the RAM's one-cycle read latency, so label_out tracks label_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bank        <= 1'b0;
            prev_valid  <= 1'b0;
            frame_done  <= 1'b0;
            err_short   <= 1'b0;
            err_over    <= 1'b0;
            label_valid <= 1'b0;
            rd_gate     <= 1'b0;
        end else begin
            state       <= state_next;
            bank        <= bank ^ complete;
            prev_valid  <= prev_valid | complete;
            frame_done  <= complete;
            err_short   <= short_end | (err_short & ~clr_err);
            err_over    <= over_hit | (err_over & ~clr_err);
            label_valid <= wr_en;
            rd_gate     <= wr_en & prev_valid;
        end
    end

endmodule

// File: tb/tb_blob_label_pingpong_ctrl.sv
// Self-checking bench: pixel-count reference model plus a vector table and directed frame sequences.
module tb_blob_label_pingpong_ctrl;

    localparam int COLS = 16;
    localparam int ROWS = 12;
    localparam int NPIX = COLS * ROWS;
    localparam int AW   = 17;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_valid, line_valid, clr_err;
    logic [7:0]    label_in;
    logic          mem_we;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [7:0]    mem_wdata, mem_rdata, label_out;
    logic          label_valid, bank, prev_valid, frame_done, err_short, err_over;

    blob_label_pingpong_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .line_valid(line_valid),
        .label_in(label_in), .clr_err(clr_err), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .label_out(label_out), .label_valid(label_valid), .bank(bank),
        .prev_valid(prev_valid), .frame_done(frame_done), .err_short(err_short),
        .err_over(err_over)
    );

    always #5 clk = ~clk;

    // Registered-read label RAM.
    logic [7:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= mem_wdata;
        mem_rdata <= ram[mem_raddr];
    end

    // Reference model state: pixel index within the frame, bank, and per-bank label images.
    int         mCount;
    bit         mBank, mPrev, mFull;
    bit         eLv, eFd, eEs, eEo;
    logic [7:0] eLo;
    logic [7:0] mMem [2][NPIX];

    int nCmp = 0, nFail = 0;
    int weCount, fdCount;

    typedef struct {
        bit            fv, lv, clr;
        logic [7:0]    lbl;
        bit            we;
        logic [AW-1:0] waddr;
        bit            lvld, es;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mCount = 0; mBank = 0; mPrev = 0; mFull = 0;
        eLv = 0; eFd = 0; eEs = 0; eEo = 0; eLo = '0;
    endtask

    task automatic modelUpdate(input bit fv, input bit lv, input logic [7:0] lbl, input bit clr);
        bit acc     = fv && lv;
        bit wasFull = mFull;
        bit esSet   = 0;
        bit done    = 0;
        eLv = 0;
        eLo = '0;
        if (acc && !wasFull) begin
            eLv = 1;
            eLo = mPrev ? mMem[!mBank][mCount] : 8'h00;
            mMem[mBank][mCount] = lbl;
            mCount++;
            if (mCount == NPIX) begin
                done = 1; mCount = 0; mBank = !mBank; mPrev = 1; mFull = 1;
            end
        end
        if (!fv) begin
            if (!wasFull && mCount > 0) begin
                esSet  = 1;
                mCount = 0;
            end
            mFull = 0;
        end
        eFd = done;
        eEs = esSet | (eEs & !clr);
        eEo = (acc && wasFull) | (eEo & !clr);
    endtask

    task automatic checkOutput();
        logic [AW-1:0] wa, ra;
        bit expWe;
        expWe = frame_valid && line_valid && !mFull;
        wa = {mBank, 8'(mCount / COLS), 8'(mCount % COLS)};
        ra = {!mBank, 8'(mCount / COLS), 8'(mCount % COLS)};
        check("mem_we", 32'(mem_we), 32'(expWe));
        check("mem_waddr", 32'(mem_waddr), 32'(wa));
        check("mem_raddr", 32'(mem_raddr), 32'(ra));
        if (expWe) check("mem_wdata", 32'(mem_wdata), 32'(label_in));
        check("label_valid", 32'(label_valid), 32'(eLv));
        check("label_out", 32'(label_out), 32'(eLo));
        check("bank", 32'(bank), 32'(mBank));
        check("prev_valid", 32'(prev_valid), 32'(mPrev));
        check("frame_done", 32'(frame_done), 32'(eFd));
        check("err_short", 32'(err_short), 32'(eEs));
        check("err_over", 32'(err_over), 32'(eEo));
        if (mem_we) weCount++;
        if (frame_done) fdCount++;
    endtask

    task automatic applyStimulus(input bit fv, input bit lv, input logic [7:0] lbl, input bit clr);
        frame_valid = fv; line_valid = lv; label_in = lbl; clr_err = clr;
        #1;
        checkOutput();
    endtask

    task automatic advance();
        @(posedge clk);
        modelUpdate(frame_valid, line_valid, label_in, clr_err);
        #1;
    endtask

    task automatic cycle(input bit fv, input bit lv, input logic [7:0] lbl, input bit clr);
        applyStimulus(fv, lv, lbl, clr);
        advance();
    endtask

    task automatic fullFrame(input bit gaps, input int seed);
        int i = 0;
        while (i < NPIX) begin
            if (gaps && (i % 2 == 1) && line_valid) begin
                cycle(1, 0, 8'h00, 0);
            end else begin
                cycle(1, 1, 8'((i % COLS) ^ (i / COLS) ^ seed), 0);
                i++;
            end
        end
    endtask

    initial begin
        bit rfv;
        rst_n = 0; frame_valid = 0; line_valid = 0; label_in = '0; clr_err = 0;
        modelReset();
        weCount = 0; fdCount = 0;

        tbl[0] = '{0, 0, 0, 8'h00, 0, 17'h00000, 0, 0};
        tbl[1] = '{1, 0, 0, 8'h00, 0, 17'h00000, 0, 0};
        tbl[2] = '{1, 1, 0, 8'h11, 1, 17'h00000, 0, 0};
        tbl[3] = '{1, 0, 0, 8'h00, 0, 17'h00001, 1, 0};
        tbl[4] = '{1, 1, 0, 8'h22, 1, 17'h00001, 0, 0};
        tbl[5] = '{1, 1, 0, 8'h33, 1, 17'h00002, 1, 0};
        tbl[6] = '{0, 0, 0, 8'h00, 0, 17'h00003, 1, 0};
        tbl[7] = '{0, 0, 0, 8'h00, 0, 17'h00000, 0, 1};
        tbl[8] = '{0, 0, 1, 8'h00, 0, 17'h00000, 0, 1};
        tbl[9] = '{0, 0, 0, 8'h00, 0, 17'h00000, 0, 0};

        // Reset state
        #2;
        checkOutput();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Vector table: start of frame, line gaps, short end, error clear
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].fv, tbl[i].lv, tbl[i].lbl, tbl[i].clr);
            check("tbl_we", 32'(mem_we), 32'(tbl[i].we));
            check("tbl_waddr", 32'(mem_waddr), 32'(tbl[i].waddr));
            check("tbl_label_valid", 32'(label_valid), 32'(tbl[i].lvld));
            check("tbl_err_short", 32'(err_short), 32'(tbl[i].es));
            advance();
        end

        // Frame 1: no previous frame, bank flips to 1
        weCount = 0; fdCount = 0;
        fullFrame(0, 0);
        cycle(0, 0, 8'h00, 0);
        check("f1_we_count", 32'(weCount), 32'(NPIX));
        check("f1_done_count", 32'(fdCount), 32'd1);
        check("f1_bank", 32'(bank), 32'd1);

        // Frame 2 with line gaps: pass B sees frame 1 labels
        weCount = 0; fdCount = 0;
        fullFrame(1, 8'h5A);
        cycle(0, 0, 8'h00, 0);
        check("f2_we_count", 32'(weCount), 32'(NPIX));
        check("f2_done_count", 32'(fdCount), 32'd1);
        check("f2_bank", 32'(bank), 32'd0);

        // Short frame: error, no swap
        for (int i = 0; i < 50; i++) cycle(1, 1, 8'(i), 0);
        cycle(0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);
        check("short_err", 32'(err_short), 32'd1);
        check("short_bank", 32'(bank), 32'd0);
        advance();
        cycle(0, 0, 8'h00, 1);

        // Overlong frame: extra accepts flagged, not written
        weCount = 0;
        fullFrame(0, 8'h33);
        for (int i = 0; i < 6; i++) cycle(1, 1, 8'hEE, 0);
        applyStimulus(0, 0, 8'h00, 1);
        check("over_we_count", 32'(weCount), 32'(NPIX));
        check("over_err", 32'(err_over), 32'd1);
        advance();
        applyStimulus(0, 0, 8'h00, 0);
        check("over_cleared", 32'(err_over), 32'd0);
        advance();

        // Randomized frames against the model
        rfv = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rfv) rfv = ($urandom_range(0, 399) != 0);
            else     rfv = ($urandom_range(0, 3) == 0);
            cycle(rfv, rfv && ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 15) == 0));
        end
        cycle(0, 0, 8'h00, 1);

        // Reset in the middle of a frame after a completed one
        fullFrame(0, 8'h0F);
        cycle(0, 0, 8'h00, 0);
        for (int i = 0; i < 100; i++) cycle(1, 1, 8'(i), 0);
        frame_valid = 1; line_valid = 1; label_in = 8'h00;
        rst_n = 0;
        #1;
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_waddr", 32'(mem_waddr), 32'd0);
        check("rst_label_valid", 32'(label_valid), 32'd0);
        check("rst_label_out", 32'(label_out), 32'd0);
        check("rst_bank", 32'(bank), 32'd0);
        check("rst_prev_valid", 32'(prev_valid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        modelReset();
        frame_valid = 0; line_valid = 0;
        @(posedge clk);
        #1 rst_n = 1;
        fullFrame(0, 8'hA5);
        cycle(0, 0, 8'h00, 0);
        check("post_rst_bank", 32'(bank), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
